// File: rtl/adc_cap_pkg.sv
// adc_cap_pkg -- shared definitions for the ADC trigger/capture block.
//   ADC_W       : sample width in bits
//   sample_t    : one ADC sample
//   cap_state_t : capture controller states
//   crossed()   : threshold-crossing test used by the trigger detector
package adc_cap_pkg;

    localparam int ADC_W = 12;

    typedef logic [ADC_W-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_TRIG,
        CAPTURE,
        READY
    } cap_state_t;

    // Rising: prev below level, current at/above. Falling: prev above, current at/below.
    function automatic logic crossed(sample_t prev, sample_t cur, sample_t lvl, logic falling);
        if (falling) return (prev > lvl) && (cur <= lvl);
        else         return (prev < lvl) && (cur >= lvl);
    endfunction

endpackage

// File: rtl/adc_trig_capture_if.sv
// adc_trig_capture_if -- buffer readout bus of adc_trig_capture.
//   rd_en    : request to read one buffered sample
//   rd_data  : buffered sample (one cycle after rd_en)
//   rd_valid : rd_data is valid this cycle
// Modports: master (reader side), slave (capture block side).
interface adc_trig_capture_if;
    import adc_cap_pkg::*;

    logic    rd_en;
    sample_t rd_data;
    logic    rd_valid;

    modport master (output rd_en, input rd_data, input rd_valid);
    modport slave  (input rd_en, output rd_data, output rd_valid);

endinterface

// File: rtl/adc_cap_ram.sv
// adc_cap_ram -- simple dual-port sample store, DEPTH x ADC_W, no reset.
//   clk            : clock
//   we/waddr/wdata : write port
//   re/raddr/rdata : synchronous read port; rdata holds while re is low
module adc_cap_ram
    import adc_cap_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  sample_t       wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output sample_t       rdata
);

    sample_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/adc_trig_capture.sv
// adc_trig_capture -- triggered ADC capture buffer with readout.
// Waits for a level crossing (or force_trig) after arm, stores DEPTH
// consecutive samples, then allows sequential readback with wrap.
//   clk_sample, rst      : sample clock, async active-high reset
//   data_in              : ADC sample, one per clock
//   arm, force_trig      : start capture / trigger immediately while waiting
//   trig_level, trig_edge: threshold and slope (0 rising, 1 falling)
//   rd                   : readout bus (rd_en, rd_data, rd_valid)
//   busy, done           : waiting/capturing, capture complete
//   peak_max, peak_min   : extremes of the captured samples
// Build option: define ADC_CAP_PEAK_EN to build peak tracking; otherwise
// peak_max/peak_min are tied to zero.
module adc_trig_capture
    import adc_cap_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic                clk_sample,
    input  logic                rst,
    input  sample_t             data_in,
    input  logic                arm,
    input  logic                force_trig,
    input  sample_t             trig_level,
    input  logic                trig_edge,
    adc_trig_capture_if.slave   rd,
    output logic                busy,
    output logic                done,
    output sample_t             peak_max,
    output sample_t             peak_min
);

    localparam int AW = $clog2(DEPTH);

    cap_state_t    state;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    sample_t       prev_s;
    logic          prev_vld;
    logic          rd_seen;
    sample_t       ram_q;

    logic          fire;
    logic          wr_en;
    logic          rd_go;
    logic [AW-1:0] ram_waddr;

    always_comb begin
        fire      = (state == WAIT_TRIG) &&
                    (force_trig || (prev_vld && crossed(prev_s, data_in, trig_level, trig_edge)));
        wr_en     = fire || (state == CAPTURE);
        // The trigger sample itself goes to address 0 in the same cycle.
        ram_waddr = (state == CAPTURE) ? wr_addr : '0;
        rd_go     = (state == READY) && rd.rd_en && !arm;
    end

    // RAM output register has no reset; rd_data reads as zero until the
    // first read after reset, then holds the last word read.
    assign rd.rd_data = rd_seen ? ram_q : '0;

    always_ff @(posedge clk_sample or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            rd.rd_valid <= 1'b0;
            wr_addr     <= '0;
            rd_addr     <= '0;
            prev_s      <= '0;
            prev_vld    <= 1'b0;
            rd_seen     <= 1'b0;
        end else begin
            prev_s      <= data_in;
            rd.rd_valid <= rd_go;
            if (rd_go) begin
                rd_addr <= rd_addr + 1'b1;
                rd_seen <= 1'b1;
            end
            case (state)
                IDLE, READY: begin
                    if (arm) begin
                        state    <= WAIT_TRIG;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        rd_addr  <= '0;
                        prev_vld <= 1'b0;
                    end
                end
                WAIT_TRIG: begin
                    prev_vld <= 1'b1;
                    if (fire) begin
                        state   <= CAPTURE;
                        wr_addr <= AW'(1);
                    end
                end
                CAPTURE: begin
                    wr_addr <= wr_addr + 1'b1;
                    if (wr_addr == AW'(DEPTH - 1)) begin
                        state <= READY;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ADC_CAP_PEAK_EN
    logic arm_go;
    assign arm_go = arm && ((state == IDLE) || (state == READY));

    always_ff @(posedge clk_sample or posedge rst) begin
        if (rst) begin
            peak_max <= '0;
            peak_min <= '1;
        end else if (arm_go) begin
            peak_max <= '0;
            peak_min <= '1;
        end else if (wr_en) begin
            if (data_in > peak_max) peak_max <= data_in;
            if (data_in < peak_min) peak_min <= data_in;
        end
    end
`else
    assign peak_max = '0;
    assign peak_min = '0;
`endif

    adc_cap_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk_sample),
        .we    (wr_en),
        .waddr (ram_waddr),
        .wdata (data_in),
        .re    (rd_go),
        .raddr (rd_addr),
        .rdata (ram_q)
    );

endmodule
